cpu_run_monitor: RTL

//  Sits directly downstream of SC_CPU: samples the CPU's PC every cycle and decides when the program has finished.

---
 rtl/cpu_run_monitor.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_monitor
//  Purpose  : Watches the CPU program counter, detects halt/timeout, counts
//             cycles and jumps, and records non-sequential PC moves in a FIFO.
//  Revision : 1.0
// ============================================================================
module cpu_run_monitor #(
    parameter int PC_STEP     = 1,
    parameter int HALT_STABLE = 4,
    parameter int MAX_CYCLES  = 100000000,
    parameter int TRACE_AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_en,
    input  logic [31:0]         pc,
    input  logic                trace_rd_en,
    output logic [63:0]         trace_data,
    output logic                trace_empty,
    output logic [TRACE_AW:0]   trace_count,
    output logic                trace_overflow,
    output logic [1:0]          state,
    output logic                halted,
    output logic                timeout,
    output logic [31:0]         cycle_count,
    output logic [31:0]         jump_count,
    output logic [31:0]         final_pc
);

    localparam logic [1:0]      c_ST_IDLE     = 2'd0;
    localparam logic [1:0]      c_ST_RUN      = 2'd1;
    localparam logic [1:0]      c_ST_HALTED   = 2'd2;
    localparam logic [1:0]      c_ST_TIMEOUT  = 2'd3;
    localparam int              c_DEPTH       = 2 ** TRACE_AW;
    localparam logic [TRACE_AW:0] c_FULL      = (TRACE_AW + 1)'(c_DEPTH);
    localparam logic [31:0]     c_PC_STEP     = 32'(PC_STEP);
    localparam logic [31:0]     c_STABLE_LAST = 32'(HALT_STABLE - 1);
    localparam logic [31:0]     c_CYCLE_LAST  = 32'(MAX_CYCLES - 1);
    localparam logic [31:0]     c_SAT         = 32'hFFFF_FFFF;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [31:0]         r_prev_pc;
    logic [31:0]         r_stable_cnt;
    logic [31:0]         r_cycle_count;
    logic [31:0]         r_jump_count;
    logic [31:0]         r_final_pc;
    logic [63:0]         r_mem [c_DEPTH];
    logic [TRACE_AW-1:0] r_wr_ptr;
    logic [TRACE_AW-1:0] r_rd_ptr;
    logic [TRACE_AW:0]   r_count;
    logic                r_overflow;

    logic w_run_edge;
    logic w_same;
    logic w_seq;
    logic w_jump;
    logic w_halt;
    logic w_timeout;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_run_edge = (r_state == c_ST_RUN) && run_en;
    assign w_same     = (pc == r_prev_pc);
    assign w_seq      = (pc == (r_prev_pc + c_PC_STEP));
    // A self-jump is treated as "stable", never as a jump event.
    assign w_jump     = w_run_edge && !w_same && !w_seq;
    assign w_halt     = w_run_edge && w_same && (r_stable_cnt == c_STABLE_LAST);
    assign w_timeout  = w_run_edge && (r_cycle_count == c_CYCLE_LAST);

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_pop      = trace_rd_en && !w_empty;
    assign w_push     = w_jump && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (run_en) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (!run_en) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_halt) begin
                    w_state_nxt = c_ST_HALTED;
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_TIMEOUT;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_pc     <= '0;
            r_stable_cnt  <= '0;
            r_cycle_count <= '0;
            r_jump_count  <= '0;
            r_final_pc    <= '0;
        end else if ((r_state == c_ST_IDLE) && run_en) begin
            r_prev_pc     <= pc;
            r_stable_cnt  <= '0;
            r_cycle_count <= '0;
            r_jump_count  <= '0;
        end else if (w_run_edge) begin
            r_prev_pc <= pc;
            if (r_cycle_count != c_SAT) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (w_same) begin
                if (r_stable_cnt != c_SAT) begin
                    r_stable_cnt <= r_stable_cnt + 32'd1;
                end
            end else begin
                r_stable_cnt <= '0;
            end
            if (w_jump && (r_jump_count != c_SAT)) begin
                r_jump_count <= r_jump_count + 32'd1;
            end
            if (w_halt || w_timeout) begin
                r_final_pc <= pc;
            end
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_prev_pc, pc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_jump && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign trace_data     = w_empty ? 64'd0 : r_mem[r_rd_ptr];
    assign trace_empty    = w_empty;
    assign trace_count    = r_count;
    assign trace_overflow = r_overflow;
    assign state          = r_state;
    assign halted         = (r_state == c_ST_HALTED);
    assign timeout        = (r_state == c_ST_TIMEOUT);
    assign cycle_count    = r_cycle_count;
    assign jump_count     = r_jump_count;
    assign final_pc       = r_final_pc;

endmodule
`default_nettype wire
